// File: rtl/rv32_writeback_arbiter.sv
// Single register-file write port shared by the one-cycle pipeline path and a
// FIFO-buffered multi-cycle path, plus the busy scoreboard decode stalls on.
module rv32_writeback_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_stall,
  input  logic        mc_issue,
  input  logic [4:0]  mc_issue_rd,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        rf_write,
  output logic [4:0]  rf_rw,
  output logic [31:0] rf_d,
  output logic [31:0] busy
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    q_rd [FIFO_DEPTH];
  logic [31:0]   q_d  [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve, starve_next;
  logic [31:0]   busy_next;
  logic          full, empty, pipe_win, xfer, mc_live, pop, push, bypass;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign mc_ready = resetn & ~full;

  always_comb begin
    pipe_win = pipe_valid && (pipe_rd != 5'd0);
    xfer     = mc_valid && mc_ready;
    // x0 results are acknowledged but never buffered or written
    mc_live  = xfer && (mc_rd != 5'd0);
    pop      = !pipe_win && !empty;
    bypass   = !pipe_win && empty && mc_live;
    push     = mc_live && !bypass;
  end

  always_comb begin
    busy_next = busy;
    if (pop)         busy_next[q_rd[head]] = 1'b0;
    else if (bypass) busy_next[mc_rd]      = 1'b0;
    // a fresh issue to the same register outranks the retiring write
    if (mc_issue && (mc_issue_rd != 5'd0)) busy_next[mc_issue_rd] = 1'b1;
  end

  always_comb begin
    starve_next = starve;
    if (empty || pop)                                     starve_next = '0;
    else if (pipe_win && (starve != SW'(STARVE_LIMIT)))   starve_next = starve + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rf_write   <= 1'b0;
      rf_rw      <= 5'd0;
      rf_d       <= 32'd0;
      busy       <= 32'd0;
      pipe_stall <= 1'b0;
      starve     <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      rf_write <= pipe_win | pop | bypass;
      if (pipe_win) begin
        rf_rw <= pipe_rd;
        rf_d  <= pipe_data;
      end else if (pop) begin
        rf_rw <= q_rd[head];
        rf_d  <= q_d[head];
      end else if (bypass) begin
        rf_rw <= mc_rd;
        rf_d  <= mc_data;
      end
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count      <= count + CW'(push) - CW'(pop);
      busy       <= busy_next;
      starve     <= starve_next;
      pipe_stall <= (starve_next == SW'(STARVE_LIMIT));
    end
  end

  // storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      q_rd[tail] <= mc_rd;
      q_d[tail]  <= mc_data;
    end
  end
endmodule

// File: tb/tb_rv32_writeback_arbiter.sv
// Scoreboarded bench: expected register-file writes are queued as stimulus is
// driven and retired by a monitor on each observed rf_write.
module tb_rv32_writeback_arbiter;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pipe_valid, mc_issue, mc_valid;
  logic [4:0]  pipe_rd, mc_issue_rd, mc_rd;
  logic [31:0] pipe_data, mc_data;
  logic        pipe_stall, mc_ready, rf_write;
  logic [4:0]  rf_rw;
  logic [31:0] rf_d, busy, busy_snap;

  wr_t sb[$];
  int  n_chk = 0;
  int  n_fail = 0;

  rv32_writeback_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .rf_write(rf_write), .rf_rw(rf_rw), .rf_d(rf_d), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
    sb.push_back('{rd: rd, d: d});
  endtask

  // retire one expected write per observed write
  always @(negedge clk) begin
    if (rf_write) begin
      if (sb.size() == 0) chk("spurious_wr", 32'(rf_write), 32'd0);
      else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_rd", 32'(rf_rw), 32'(e.rd));
        chk("wr_d", rf_d, e.d);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    mc_issue = 0; mc_issue_rd = 0; mc_valid = 0; mc_rd = 0; mc_data = 0;
    tick(); tick();
    chk("rst_rf_write", 32'(rf_write), 0);
    chk("rst_busy", busy, 0);
    chk("rst_mc_ready", 32'(mc_ready), 0);
    chk("rst_stall", 32'(pipe_stall), 0);
    resetn = 1'b1; #1;
    chk("rel_mc_ready", 32'(mc_ready), 1);
    tick();

    // reset with two stale FIFO entries
    mc_issue = 1; mc_issue_rd = 12; tick();
    mc_issue_rd = 13; tick();
    mc_issue = 0;
    chk("stale_busy_set", busy, 32'h0000_3000);
    pipe_valid = 1; pipe_rd = 10; pipe_data = 32'hA0; exp_wr(10, 32'hA0);
    mc_valid = 1; mc_rd = 12; mc_data = 32'hC12; tick();
    pipe_data = 32'hA1; exp_wr(10, 32'hA1);
    mc_rd = 13; mc_data = 32'hC13; tick();
    mc_valid = 0; pipe_valid = 0;
    chk("stale_full_ready", 32'(mc_ready), 0);
    resetn = 0; #1;
    chk("stale_rst_ready", 32'(mc_ready), 0);
    tick();
    chk("stale_rf_write", 32'(rf_write), 0);
    chk("stale_busy", busy, 0);
    resetn = 1; #1;
    chk("stale_ready", 32'(mc_ready), 1);
    tick(); tick(); tick();
    chk("stale_no_wr", 32'(sb.size()), 0);

    // pipeline only
    pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF; exp_wr(5, 32'hDEADBEEF);
    tick();
    chk("pipe_write", 32'(rf_write), 1);
    chk("pipe_rw", 32'(rf_rw), 5);
    chk("pipe_d", rf_d, 32'hDEADBEEF);
    pipe_rd = 0; pipe_data = 32'h1234; tick();
    chk("pipe_x0_write", 32'(rf_write), 0);
    chk("pipe_x0_hold", 32'(rf_rw), 5);
    pipe_valid = 0;

    // collision: pipe wins, mc result follows one cycle later
    mc_issue = 1; mc_issue_rd = 7; tick();
    mc_issue = 0;
    chk("col_busy_set", 32'(busy[7]), 1);
    pipe_valid = 1; pipe_rd = 3; pipe_data = 32'h11; exp_wr(3, 32'h11);
    mc_valid = 1; mc_rd = 7; mc_data = 32'h22; exp_wr(7, 32'h22);
    tick();
    pipe_valid = 0; mc_valid = 0;
    chk("col_k1_rw", 32'(rf_rw), 3);
    chk("col_k1_busy", 32'(busy[7]), 1);
    tick();
    chk("col_k2_write", 32'(rf_write), 1);
    chk("col_k2_rw", 32'(rf_rw), 7);
    chk("col_k2_busy", 32'(busy[7]), 0);
    tick();
    chk("col_idle", 32'(rf_write), 0);

    // back-pressure and starvation
    for (int r = 20; r < 23; r++) begin
      mc_issue = 1; mc_issue_rd = 5'(r); tick();
    end
    mc_issue = 0;
    chk("stv_busy_set", busy & 32'h0070_0000, 32'h0070_0000);
    for (int i = 0; i < 6; i++) begin
      pipe_valid = 1; pipe_rd = 5'(i + 1); pipe_data = 32'h100 + 32'(i);
      exp_wr(5'(i + 1), 32'h100 + 32'(i));
      mc_valid = 1;
      mc_rd   = (i == 0) ? 5'd20 : (i == 1) ? 5'd21 : 5'd22;
      mc_data = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hC;
      #1;
      chk($sformatf("stv_ready_%0d", i), 32'(mc_ready), (i >= 2) ? 1'b0 : 1'b1);
      tick();
      chk($sformatf("stv_stall_%0d", i), 32'(pipe_stall), (i >= 4) ? 1'b1 : 1'b0);
    end
    pipe_valid = 0;
    exp_wr(20, 32'hA); exp_wr(21, 32'hB); exp_wr(22, 32'hC);
    tick();
    chk("stv_drain_stall", 32'(pipe_stall), 0);
    chk("stv_drain_ready", 32'(mc_ready), 1);
    tick();
    mc_valid = 0;
    tick(); tick();
    chk("stv_busy_clr", busy & 32'h0070_0000, 0);
    chk("stv_sb_empty", 32'(sb.size()), 0);

    // scoreboard: new issue on the retire edge keeps the bit set
    mc_issue = 1; mc_issue_rd = 9; tick();
    chk("sb_busy9", 32'(busy[9]), 1);
    mc_valid = 1; mc_rd = 9; mc_data = 32'h99; exp_wr(9, 32'h99);
    tick();
    mc_issue = 0;
    chk("sb_setwins_wr", 32'(rf_write), 1);
    chk("sb_setwins_busy", 32'(busy[9]), 1);
    mc_data = 32'h98; exp_wr(9, 32'h98);
    tick();
    mc_valid = 0;
    chk("sb_clear_busy", 32'(busy[9]), 0);

    // x0 on the mc path: acknowledged, no write, busy untouched
    mc_issue = 1; mc_issue_rd = 17; tick();
    mc_issue = 0;
    busy_snap = busy;
    mc_valid = 1; mc_rd = 0; mc_data = 32'h55; #1;
    chk("x0_ready", 32'(mc_ready), 1);
    tick();
    mc_valid = 0;
    chk("x0_no_write", 32'(rf_write), 0);
    chk("x0_busy", busy, busy_snap);
    tick();
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
